sc_speed_selector: RTL and testbench

SC_SPEED_SELECTOR -- requirements
Module: sc_speed_selector

---
 rtl/sc_speed_selector_pkg.sv | 30 +++
 rtl/sc_button_edge.sv | 30 +++
 rtl/sc_speed_selector.sv | 102 ++++++++++
 tb/tb_sc_speed_selector.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sc_speed_selector_pkg.sv
// Shared definitions for the speed selector and the downstream velocity counter:
// FSM state encoding, 2-bit speed codes and the lockout counter width.
package sc_speed_selector_pkg;

   typedef enum logic [2:0] {
      ST_STOP,
      ST_VEL1,
      ST_VEL2,
      ST_VEL3,
      ST_PENALTY
   } state_t;

   typedef logic [1:0] speed_code_t;

   localparam speed_code_t SPEED_SLOW   = 2'b01;
   localparam speed_code_t SPEED_MEDIUM = 2'b10;
   localparam speed_code_t SPEED_FAST   = 2'b11;

   localparam int unsigned PENALTY_CNT_W = 27;

   // Speed code presented for a given state; never returns 00.
   function automatic speed_code_t speed_code(input state_t s);
      case (s)
         ST_VEL2: speed_code = SPEED_MEDIUM;
         ST_VEL3: speed_code = SPEED_FAST;
         default: speed_code = SPEED_SLOW;
      endcase
   endfunction

endpackage

// File: rtl/sc_button_edge.sv
// Two-flop synchronizer plus previous-value register for an active-low
// pushbutton; emits a one-cycle pulse on each new press (1 -> 0 transition).
module sc_button_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn_n,
   output logic o_press
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   // Synchronize the raw button and keep its previous synchronized value;
   // all flops reset to the released level so reset release makes no event.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= i_btn_n;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign o_press = ~r_sync2 & r_prev;

endmodule

// File: rtl/sc_speed_selector.sv
// Speed selector FSM: accel/brake buttons step the speed code, a crash forces
// a timed lockout (PENALTY) after which the vehicle restarts from STOP.
import sc_speed_selector_pkg::*;

module sc_speed_selector #(
   parameter int unsigned PENALTY_CYCLES = 100000000
) (
   input  logic       SC_SPEED_SELECTOR_CLOCK_50,
   input  logic       SC_SPEED_SELECTOR_RESET_InLow,
   input  logic       SC_SPEED_SELECTOR_ACCEL_InLow,
   input  logic       SC_SPEED_SELECTOR_BRAKE_InLow,
   input  logic       SC_SPEED_SELECTOR_CRASH_InLow,
   output logic [1:0] SC_SPEED_SELECTOR_SELECTIONVEL_OutBus,
   output logic       SC_SPEED_SELECTOR_ENABLE_OutLow,
   output logic       SC_SPEED_SELECTOR_PENALTY_OutLow
);

   localparam logic [PENALTY_CNT_W-1:0] PENALTY_LOAD = PENALTY_CNT_W'(PENALTY_CYCLES - 1);

   logic                     w_accel;
   logic                     w_brake;
   state_t                   r_state;
   state_t                   w_state_next;
   logic [PENALTY_CNT_W-1:0] r_cnt;
   logic [PENALTY_CNT_W-1:0] w_cnt_next;
   speed_code_t              r_sel;
   logic                     r_en_n;
   logic                     r_pen_n;

   sc_button_edge u_accel (
      .i_clk   (SC_SPEED_SELECTOR_CLOCK_50),
      .i_rst_n (SC_SPEED_SELECTOR_RESET_InLow),
      .i_btn_n (SC_SPEED_SELECTOR_ACCEL_InLow),
      .o_press (w_accel)
   );

   sc_button_edge u_brake (
      .i_clk   (SC_SPEED_SELECTOR_CLOCK_50),
      .i_rst_n (SC_SPEED_SELECTOR_RESET_InLow),
      .i_btn_n (SC_SPEED_SELECTOR_BRAKE_InLow),
      .o_press (w_brake)
   );

   // Next-state logic: crash overrides everything, brake wins over accel,
   // button events are ignored while the lockout counter runs.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      if (!SC_SPEED_SELECTOR_CRASH_InLow) begin
         w_state_next = ST_PENALTY;
         w_cnt_next   = PENALTY_LOAD;
      end else begin
         case (r_state)
            ST_STOP: begin
               if (!w_brake && w_accel) w_state_next = ST_VEL1;
            end
            ST_VEL1: begin
               if (w_brake)      w_state_next = ST_STOP;
               else if (w_accel) w_state_next = ST_VEL2;
            end
            ST_VEL2: begin
               if (w_brake)      w_state_next = ST_VEL1;
               else if (w_accel) w_state_next = ST_VEL3;
            end
            ST_VEL3: begin
               if (w_brake)      w_state_next = ST_VEL2;
            end
            ST_PENALTY: begin
               if (r_cnt == '0) w_state_next = ST_STOP;
               else             w_cnt_next   = r_cnt - 1'b1;
            end
            default: begin
               w_state_next = ST_STOP;
               w_cnt_next   = '0;
            end
         endcase
      end
   end

   // State, lockout counter and registered outputs; outputs are decoded from
   // the next state so they change on the same edge as the state.
   always_ff @(posedge SC_SPEED_SELECTOR_CLOCK_50 or negedge SC_SPEED_SELECTOR_RESET_InLow) begin
      if (!SC_SPEED_SELECTOR_RESET_InLow) begin
         r_state <= ST_STOP;
         r_cnt   <= '0;
         r_sel   <= SPEED_SLOW;
         r_en_n  <= 1'b1;
         r_pen_n <= 1'b1;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_sel   <= speed_code(w_state_next);
         r_en_n  <= (w_state_next == ST_STOP) || (w_state_next == ST_PENALTY);
         r_pen_n <= (w_state_next != ST_PENALTY);
      end
   end

   assign SC_SPEED_SELECTOR_SELECTIONVEL_OutBus = r_sel;
   assign SC_SPEED_SELECTOR_ENABLE_OutLow       = r_en_n;
   assign SC_SPEED_SELECTOR_PENALTY_OutLow      = r_pen_n;

endmodule

// File: tb/tb_sc_speed_selector.sv
// Directed self-checking bench for sc_speed_selector with an 8-cycle lockout.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sc_speed_selector;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       accel_n;
   logic       brake_n;
   logic       crash_n;
   logic [1:0] sel;
   logic       en_n;
   logic       pen_n;
   logic [3:0] obs;

   int n_checks = 0;
   int n_fail   = 0;

   // {SEL, ENABLE, PENALTY}
   localparam logic [3:0] O_STOP = 4'b0111;
   localparam logic [3:0] O_VEL1 = 4'b0101;
   localparam logic [3:0] O_VEL2 = 4'b1001;
   localparam logic [3:0] O_VEL3 = 4'b1101;
   localparam logic [3:0] O_PEN  = 4'b0110;

   sc_speed_selector #(.PENALTY_CYCLES(8)) dut (
      .SC_SPEED_SELECTOR_CLOCK_50            (clk),
      .SC_SPEED_SELECTOR_RESET_InLow         (rst_n),
      .SC_SPEED_SELECTOR_ACCEL_InLow         (accel_n),
      .SC_SPEED_SELECTOR_BRAKE_InLow         (brake_n),
      .SC_SPEED_SELECTOR_CRASH_InLow         (crash_n),
      .SC_SPEED_SELECTOR_SELECTIONVEL_OutBus (sel),
      .SC_SPEED_SELECTOR_ENABLE_OutLow       (en_n),
      .SC_SPEED_SELECTOR_PENALTY_OutLow      (pen_n)
   );

   assign obs = {sel, en_n, pen_n};

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running exp finished");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; accel_n = 1'b1; brake_n = 1'b1; crash_n = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (obs !== O_STOP) begin n_fail++; $display("FAIL reset_held: got %b exp %b", obs, O_STOP); end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (obs !== O_STOP) begin n_fail++; $display("FAIL reset_release[%0d]: got %b exp %b", i, obs, O_STOP); end
      end
   endtask

   task automatic test_accel_steps();
      logic [3:0] exp_tab [3];
      logic [3:0] prev;
      exp_tab = '{O_VEL1, O_VEL2, O_VEL3};
      prev = O_STOP;
      for (int p = 0; p < 3; p++) begin
         accel_n = 1'b0;
         step();                          // edge k
         step();                          // edge k+1
         n_checks++;
         if (obs !== prev) begin n_fail++; $display("FAIL accel_early[%0d]: got %b exp %b", p, obs, prev); end
         step();                          // edge k+2
         n_checks++;
         if (obs !== exp_tab[p]) begin n_fail++; $display("FAIL accel_step[%0d]: got %b exp %b", p, obs, exp_tab[p]); end
         step(); step();
         accel_n = 1'b1;
         repeat (3) step();
         n_checks++;
         if (obs !== exp_tab[p]) begin n_fail++; $display("FAIL accel_settle[%0d]: got %b exp %b", p, obs, exp_tab[p]); end
         prev = exp_tab[p];
      end
   endtask

   task automatic test_accel_hold();
      int bad = 0;
      accel_n = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         n_checks++;
         if (obs !== O_VEL3) begin n_fail++; bad++; if (bad < 4) $display("FAIL accel_hold[%0d]: got %b exp %b", i, obs, O_VEL3); end
      end
      accel_n = 1'b1;
      repeat (3) step();
   endtask

   task automatic test_brake();
      brake_n = 1'b0;
      step(); step();
      n_checks++;
      if (obs !== O_VEL3) begin n_fail++; $display("FAIL brake_early: got %b exp %b", obs, O_VEL3); end
      step();
      n_checks++;
      if (obs !== O_VEL2) begin n_fail++; $display("FAIL brake_step: got %b exp %b", obs, O_VEL2); end
      brake_n = 1'b1;
      repeat (3) step();
   endtask

   task automatic test_simultaneous();
      accel_n = 1'b0; brake_n = 1'b0;
      step(); step();
      n_checks++;
      if (obs !== O_VEL2) begin n_fail++; $display("FAIL simul_early: got %b exp %b", obs, O_VEL2); end
      step();
      n_checks++;
      if (obs !== O_VEL1) begin n_fail++; $display("FAIL simul_brake_wins: got %b exp %b", obs, O_VEL1); end
      accel_n = 1'b1; brake_n = 1'b1;
      repeat (3) step();
      n_checks++;
      if (obs !== O_VEL1) begin n_fail++; $display("FAIL simul_settle: got %b exp %b", obs, O_VEL1); end
   endtask

   task automatic press_accel_once();
      accel_n = 1'b0;
      step();
      accel_n = 1'b1;
      repeat (3) step();
   endtask

   task automatic test_crash();
      press_accel_once();
      press_accel_once();
      n_checks++;
      if (obs !== O_VEL3) begin n_fail++; $display("FAIL crash_setup: got %b exp %b", obs, O_VEL3); end
      crash_n = 1'b0;
      step();                             // edge e
      crash_n = 1'b1;
      n_checks++;
      if (obs !== O_PEN) begin n_fail++; $display("FAIL crash_enter: got %b exp %b", obs, O_PEN); end
      for (int i = 1; i < 8; i++) begin
         if (i == 2) accel_n = 1'b0;
         if (i == 3) accel_n = 1'b1;
         step();
         n_checks++;
         if (obs !== O_PEN) begin n_fail++; $display("FAIL crash_lock[%0d]: got %b exp %b", i, obs, O_PEN); end
      end
      step();                             // edge e+8
      n_checks++;
      if (obs !== O_STOP) begin n_fail++; $display("FAIL crash_exit: got %b exp %b", obs, O_STOP); end
      repeat (3) step();
      n_checks++;
      if (obs !== O_STOP) begin n_fail++; $display("FAIL crash_after: got %b exp %b", obs, O_STOP); end
   endtask

   task automatic test_crash_extend();
      crash_n = 1'b0;
      step();                             // edge e1
      crash_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         n_checks++;
         if (obs !== O_PEN) begin n_fail++; $display("FAIL ext_first[%0d]: got %b exp %b", i, obs, O_PEN); end
      end
      crash_n = 1'b0;
      step();                             // edge e2 = e1+4
      crash_n = 1'b1;
      n_checks++;
      if (obs !== O_PEN) begin n_fail++; $display("FAIL ext_reload: got %b exp %b", obs, O_PEN); end
      for (int i = 1; i < 8; i++) begin
         if (i == 5) accel_n = 1'b0;
         step();
         n_checks++;
         if (obs !== O_PEN) begin n_fail++; $display("FAIL ext_lock[%0d]: got %b exp %b", i, obs, O_PEN); end
      end
      for (int i = 0; i < 6; i++) begin
         step();
         n_checks++;
         if (obs !== O_STOP) begin n_fail++; $display("FAIL ext_exit_held[%0d]: got %b exp %b", i, obs, O_STOP); end
      end
      accel_n = 1'b1;
      repeat (3) step();
   endtask

   task automatic test_reset_mid_penalty();
      press_accel_once();
      n_checks++;
      if (obs !== O_VEL1) begin n_fail++; $display("FAIL rstpen_setup: got %b exp %b", obs, O_VEL1); end
      crash_n = 1'b0;
      step();
      crash_n = 1'b1;
      step(); step();
      n_checks++;
      if (obs !== O_PEN) begin n_fail++; $display("FAIL rstpen_cycle3: got %b exp %b", obs, O_PEN); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs !== O_STOP) begin n_fail++; $display("FAIL rstpen_async: got %b exp %b", obs, O_STOP); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (obs !== O_STOP) begin n_fail++; $display("FAIL rstpen_release[%0d]: got %b exp %b", i, obs, O_STOP); end
      end
      accel_n = 1'b0;
      step(); step();
      n_checks++;
      if (obs !== O_STOP) begin n_fail++; $display("FAIL rstpen_early: got %b exp %b", obs, O_STOP); end
      step();
      n_checks++;
      if (obs !== O_VEL1) begin n_fail++; $display("FAIL rstpen_accel: got %b exp %b", obs, O_VEL1); end
      accel_n = 1'b1;
      repeat (3) step();
   endtask

   initial begin
      test_reset();
      test_accel_steps();
      test_accel_hold();
      test_brake();
      test_simultaneous();
      test_crash();
      test_crash_extend();
      test_reset_mid_penalty();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
